// File: rtl/uart_pkg.sv
// Shared UART definitions: TX arbiter FSM encoding, requester limit and timeout default.
package uart_pkg;

    localparam int unsigned NUM_REQ_MAX      = 8;
    localparam int unsigned BUSY_TIMEOUT_DEF = 16;
    localparam int unsigned BYTE_W           = 8;
    localparam int unsigned COUNT_W          = 16;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_START     = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set bit of req searching upward from ptr, wrapping at N-1.
module rr_picker #(
    parameter int unsigned N = 4,
    localparam int unsigned W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] winner,
    output logic         any
);

    logic [W-1:0] idx;

    // Scan offsets from farthest to nearest so the nearest set bit overwrites the rest.
    always_comb begin
        winner = ptr;
        idx    = ptr;
        for (int k = int'(N) - 1; k >= 0; k--) begin
            idx = W'((int'(ptr) + k) % int'(N));
            if (req[idx]) begin
                winner = idx;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX core among NUM_REQ byte requesters.
// Optional packet lock (keep serving one requester until req_last): UART_TX_ARB_PACKET_LOCK_EN.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned BUSY_TIMEOUT = BUSY_TIMEOUT_DEF,
    localparam int unsigned ID_W        = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [BYTE_W*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      tx_start,
    output logic [BYTE_W-1:0]         tx_data,
    input  logic                      tx_busy,
    output logic [ID_W-1:0]           grant_id,
    output logic                      arb_busy,
    output logic [COUNT_W-1:0]        byte_count,
    output logic                      err_timeout
);

    localparam int unsigned TO_W = $clog2(BUSY_TIMEOUT + 1);

    arb_state_t        state;
    logic [ID_W-1:0]   rr_ptr;
    logic [TO_W-1:0]   to_cnt;
    logic [ID_W-1:0]   next_id;
    logic [NUM_REQ-1:0] pick_req;
    logic [ID_W-1:0]   pick_winner;
    logic              pick_any;
    logic [BYTE_W-1:0] req_bytes [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_bytes
        assign req_bytes[i] = req_data[BYTE_W*i +: BYTE_W];
    end

    assign next_id = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);

`ifdef UART_TX_ARB_PACKET_LOCK_EN
    logic lock;
    logic last_q;

    // While locked only the current owner is eligible; the picker then returns grant_id.
    assign pick_req = lock ? (req_valid & (NUM_REQ'(1) << grant_id)) : req_valid;
`else
    logic unused_last;

    assign pick_req    = req_valid;
    assign unused_last = ^req_last;
`endif

    rr_picker #(
        .N (NUM_REQ)
    ) u_picker (
        .req    (pick_req),
        .ptr    (rr_ptr),
        .winner (pick_winner),
        .any    (pick_any)
    );

    // Arbitration FSM; every output is registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            rr_ptr      <= '0;
            grant_id    <= '0;
            tx_data     <= '0;
            tx_start    <= 1'b0;
            req_ready   <= '0;
            arb_busy    <= 1'b0;
            byte_count  <= '0;
            err_timeout <= 1'b0;
            to_cnt      <= '0;
`ifdef UART_TX_ARB_PACKET_LOCK_EN
            lock        <= 1'b0;
            last_q      <= 1'b0;
`endif
        end else begin
            tx_start  <= 1'b0;
            req_ready <= '0;
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        tx_data    <= req_bytes[pick_winner];
                        grant_id   <= pick_winner;
                        tx_start   <= 1'b1;
                        req_ready  <= NUM_REQ'(1) << pick_winner;
                        byte_count <= byte_count + COUNT_W'(1);
                        arb_busy   <= 1'b1;
                        state      <= ST_START;
`ifdef UART_TX_ARB_PACKET_LOCK_EN
                        last_q     <= req_last[pick_winner];
`endif
                    end
                end
                ST_START: begin
                    to_cnt <= '0;
                    state  <= ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY: begin
                    if (tx_busy) begin
                        state <= ST_WAIT_DONE;
                    end else if (to_cnt == TO_W'(BUSY_TIMEOUT - 1)) begin
                        // Core never acknowledged: flag it, drop any lock and move on.
                        err_timeout <= 1'b1;
                        rr_ptr      <= next_id;
                        arb_busy    <= 1'b0;
                        state       <= ST_IDLE;
`ifdef UART_TX_ARB_PACKET_LOCK_EN
                        lock        <= 1'b0;
`endif
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                ST_WAIT_DONE: begin
                    if (!tx_busy) begin
                        arb_busy <= 1'b0;
                        state    <= ST_IDLE;
`ifdef UART_TX_ARB_PACKET_LOCK_EN
                        if (last_q) begin
                            lock   <= 1'b0;
                            rr_ptr <= next_id;
                        end else begin
                            lock   <= 1'b1;
                        end
`else
                        rr_ptr   <= next_id;
`endif
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: random requesters and TX core model against a cycle-level reference.
module tb_uart_tx_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned TO = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic           tx_start;
    logic [7:0]     tx_data;
    logic           tx_busy;
    logic [1:0]     grant_id;
    logic           arb_busy;
    logic [15:0]    byte_count;
    logic           err_timeout;

    uart_tx_arbiter #(.NUM_REQ(N), .BUSY_TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_busy     (tx_busy),
        .grant_id    (grant_id),
        .arb_busy    (arb_busy),
        .byte_count  (byte_count),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Per-requester byte streams ({last, data}): src_q feeds the pins, exp_q feeds the scoreboard.
    logic [8:0] src_q [N][$];
    logic [8:0] exp_q [N][$];

    bit hold       = 1'b0;
    int gen_pct    = 0;
    bit tx_dead    = 1'b0;
    bit frame_rand = 1'b0;
    bit preload    = 1'b0;

    // Reference model state.
    bit          m_idle;
    int          m_ptr;
    int          m_owner;
    logic [7:0]  m_data;
    logic [15:0] m_count;
    bit          m_err;
    bit          m_lock;
    bit          m_last;
    int          m_launch;
    bit          m_seen_high;
    int          cyc = 0;
    logic [N-1:0] prev_valid = '0;
    logic        prev_busy   = 1'b0;
    logic        rst_q       = 1'b1;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    function automatic void model_reset();
        m_idle = 1; m_ptr = 0; m_owner = 0; m_data = 8'h00; m_count = 16'h0000;
        m_err = 0; m_lock = 0; m_last = 0; m_launch = 0; m_seen_high = 0;
    endfunction

    function automatic bit eligible(logic [N-1:0] v);
        if (m_lock) return v[m_owner];
        return |v;
    endfunction

    function automatic int pick(logic [N-1:0] v);
        if (m_lock) return m_owner;
        for (int k = 0; k < N; k++) begin
            if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return 0;
    endfunction

    function automatic void finish_frame(bit timed_out);
        m_idle = 1;
`ifdef UART_TX_ARB_PACKET_LOCK_EN
        if (!timed_out && !m_last) begin
            m_lock = 1;
            return;
        end
        m_lock = 0;
`endif
        m_ptr = (m_owner + 1) % N;
    endfunction

    // Monitor: advance the model by one cycle from the previous cycle's inputs, then compare outputs.
    always @(negedge clk) begin : monitor
        logic       exp_start;
        int         w;
        logic [8:0] ent;
        cyc++;
        exp_start = 1'b0;
        w = 0;
        if (rst_q) begin
            model_reset();
        end else if (m_idle) begin
            if (eligible(prev_valid)) begin
                exp_start = 1'b1;
                w = pick(prev_valid);
                if (exp_q[w].size() == 0) begin
                    checks++; errors++;
                    $display("FAIL scoreboard_empty: launch for requester %0d with nothing queued (cycle %0d)", w, cyc);
                end else begin
                    ent = exp_q[w].pop_front();
                    m_data = ent[7:0];
                    m_last = ent[8];
                end
                m_owner = w;
                m_count = m_count + 16'd1;
                m_idle = 0;
                m_launch = cyc;
                m_seen_high = 0;
            end
        end else if (!m_seen_high) begin
            if (prev_busy && (cyc - 1) >= m_launch + 1) begin
                m_seen_high = 1;
            end else if ((cyc - 1) == m_launch + TO) begin
                m_err = 1;
                finish_frame(1'b1);
            end
        end else if (!prev_busy) begin
            finish_frame(1'b0);
        end
        if (preload) m_count = 16'hFFFD;

        chk("tx_start", 32'(tx_start), 32'(exp_start));
        chk("req_ready", 32'(req_ready), exp_start ? (32'd1 << w) : 32'd0);
        chk("arb_busy", 32'(arb_busy), 32'(!m_idle));
        chk("grant_id", 32'(grant_id), 32'(m_owner));
        chk("tx_data", 32'(tx_data), 32'(m_data));
        chk("byte_count", 32'(byte_count), 32'(m_count));
        chk("err_timeout", 32'(err_timeout), 32'(m_err));

        prev_valid = req_valid;
        prev_busy  = tx_busy;
        rst_q      = rst;
    end

    // TX core model: busy from the cycle after tx_start for a frame time; occasionally silent.
    initial begin : tx_core
        int len;
        tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_start === 1'b1 && !tx_dead && !(frame_rand && $urandom_range(0, 7) == 0)) begin
                len = frame_rand ? int'($urandom_range(1, 20)) : 20;
                @(posedge clk); #1 tx_busy = 1'b1;
                repeat (len) @(posedge clk);
                #1 tx_busy = 1'b0;
            end
        end
    end

    function automatic void push_byte(int i, logic [7:0] d, logic l);
        src_q[i].push_back({l, d});
        exp_q[i].push_back({l, d});
    endfunction

    function automatic bit pending();
        for (int i = 0; i < N; i++) if (src_q[i].size() != 0) return 1;
        return 0;
    endfunction

    task automatic drive();
        logic [8:0] e;
        for (int i = 0; i < N; i++) begin
            e = (src_q[i].size() != 0) ? src_q[i][0] : 9'h000;
            req_valid[i]      = !hold && (src_q[i].size() != 0);
            req_data[8*i +: 8] = e[7:0];
            req_last[i]       = e[8];
        end
    endtask

    task automatic step();
        logic [N-1:0] rdy;
        @(negedge clk);
        rdy = req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (rdy[i] && src_q[i].size() != 0) void'(src_q[i].pop_front());
        end
        if (gen_pct > 0) begin
            for (int i = 0; i < N; i++) begin
                if (src_q[i].size() < 4 && $urandom_range(0, 99) < gen_pct)
                    push_byte(i, 8'($urandom), 1'($urandom_range(0, 3) != 0));
            end
        end
        drive();
    endtask

    task automatic wait_drain(int limit);
        int n;
        n = 0;
        while ((pending() || arb_busy || tx_busy) && n < limit) begin
`ifdef UART_TX_ARB_PACKET_LOCK_EN
            if (m_lock && src_q[m_owner].size() == 0) begin
                push_byte(m_owner, 8'($urandom), 1'b1);
                drive();
            end
`endif
            step();
            n++;
        end
        checks++;
        if (n >= limit) begin
            errors++;
            $display("FAIL drain_timeout: still busy after %0d cycles, required idle (cycle %0d)", n, cyc);
        end
    endtask

    task automatic wait_busy_high(int limit);
        int n;
        n = 0;
        while (!tx_busy && n < limit) begin
            step();
            n++;
        end
        checks++;
        if (n >= limit) begin
            errors++;
            $display("FAIL tx_busy_wait: got 0 after %0d cycles, required 1", n);
        end
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        rst = 1'b1;
        req_valid = '0; req_data = '0; req_last = '0;
        repeat (3) step();
        rst = 1'b0;
        drive();
        repeat (2) step();

        // Single request from requester 2.
        push_byte(2, 8'h41, 1'b1);
        drive();
        wait_drain(200);

        // All four requesting back to back with 20-cycle frames.
        for (int i = 0; i < N; i++)
            for (int k = 0; k < 3; k++) push_byte(i, 8'(16 * i + k), 1'b1);
        drive();
        wait_drain(1500);

        // Requester 1 sends a 3-byte packet while requester 0 also waits.
        push_byte(0, 8'hA0, 1'b1);
        push_byte(1, 8'hB0, 1'b0);
        push_byte(1, 8'hB1, 1'b0);
        push_byte(1, 8'hB2, 1'b1);
        drive();
        wait_drain(500);

        // Core never answers: timeout, then normal service resumes.
        tx_dead = 1'b1;
        push_byte(1, 8'hE1, 1'b1);
        drive();
        wait_drain(100);
        tx_dead = 1'b0;
        push_byte(3, 8'hE3, 1'b1);
        drive();
        wait_drain(100);

        // Random traffic with random frame lengths and occasional silent frames.
        frame_rand = 1'b1;
        gen_pct = 25;
        repeat (1500) step();
        gen_pct = 0;
        wait_drain(3000);
        frame_rand = 1'b0;

        // Reset during WAIT_DONE of a requester-1 byte; pointer must restart at 0.
        push_byte(1, 8'h5A, 1'b1);
        drive();
        wait_busy_high(50);
        repeat (3) step();
        hold = 1'b1;
        rst = 1'b1;
        drive();
        repeat (2) step();
        rst = 1'b0;
        drive();
        wait_drain(100);
        hold = 1'b0;
        push_byte(0, 8'h70, 1'b1);
        push_byte(3, 8'h73, 1'b1);
        drive();
        wait_drain(200);

        // Byte counter wrap from a preloaded value.
        force dut.byte_count = 16'hFFFD;
        preload = 1'b1;
        step();
        release dut.byte_count;
        preload = 1'b0;
        for (int i = 0; i < N; i++) push_byte(i, 8'(8'hC0 + i), 1'b1);
        drive();
        wait_drain(500);
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
